// File: rtl/div_serial_if.sv
// Request/response bundle between the M-extension execute stage (master)
// and the serial divide engine (slave).
interface div_serial_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            is_q_i;
  logic            ready_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output req_i, a_i, b_i, is_q_i,
    input  ready_o, result_o
  );

  modport slave (
    input  req_i, a_i, b_i, is_q_i,
    output ready_o, result_o
  );
endinterface

// File: rtl/div_serial.sv
// Multi-cycle unsigned radix-2 restoring divider, one quotient bit per cycle.
// Divide-by-zero short-circuits to all-ones quotient / dividend remainder.
module div_serial #(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  div_serial_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;
  logic            mode;
  logic            ready_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN:0]   rem_sh;
  logic            no_borrow;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  // The shifted remainder needs XLEN+1 bits; when it is >= divisor the true
  // difference fits in XLEN bits, so the low-word subtract is exact.
  always_comb begin
    rem_sh    = {rem, quo[XLEN-1]};
    no_borrow = (rem_sh >= {1'b0, divisor});
    rem_nxt   = no_borrow ? (rem_sh[XLEN-1:0] - divisor) : rem_sh[XLEN-1:0];
    quo_nxt   = {quo[XLEN-2:0], no_borrow};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      mode     <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            if (bus.b_i == '0) begin
              result_q <= bus.is_q_i ? '1 : bus.a_i;
              ready_q  <= 1'b1;
              state    <= DONE;
            end else begin
              quo     <= bus.a_i;
              divisor <= bus.b_i;
              mode    <= bus.is_q_i;
              rem     <= '0;
              cnt     <= CW'(XLEN);
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          // Dropping req_i abandons the divide silently; result_q is kept.
          if (!bus.req_i) begin
            state <= IDLE;
          end else begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              result_q <= mode ? quo_nxt : rem_nxt;
              ready_q  <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_serial.sv
// Directed plus randomized bench for div_serial (XLEN=32) against an
// arithmetic reference of quotient/remainder and handshake latency.
module tb_div_serial;

  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  div_serial_if #(.XLEN(XLEN)) bus ();

  div_serial #(.XLEN(XLEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ref_div(input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b,
                                              input logic q);
    if (b == 0) return q ? {XLEN{1'b1}} : a;
    return q ? (a / b) : (a % b);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the pulse, check latency, result and pulse width.
  task automatic do_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic q, input string tag);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    bus.a_i    = a;
    bus.b_i    = b;
    bus.is_q_i = q;
    bus.req_i  = 1'b1;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (bus.ready_o) got = 1;
    end
    bus.req_i = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), (b == 0) ? 64'd1 : 64'(XLEN + 1));
    chk({tag, "_res"}, 64'(bus.result_o), 64'(ref_div(a, b, q)));
    tick();
    chk({tag, "_pulse"}, 64'(bus.ready_o), 64'd0);
  endtask

  initial begin
    int cyc;
    int t1;
    int t2;
    bit seen;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    logic            rq;

    errors = 0;
    checks = 0;
    rst_n      = 1'b0;
    bus.req_i  = 1'b0;
    bus.a_i    = '0;
    bus.b_i    = '0;
    bus.is_q_i = 1'b0;

    // Reset and idle
    repeat (3) tick();
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", 64'(bus.result_o), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      tick();
      seen |= bus.ready_o;
    end
    chk("idle_no_pulse", 64'(seen), 64'd0);
    chk("idle_result", 64'(bus.result_o), 64'd0);

    // Basic and divide-by-zero
    do_op(32'd100, 32'd7, 1'b1, "q100_7");
    do_op(32'd100, 32'd7, 1'b0, "r100_7");
    do_op(32'hDEADBEEF, 32'd0, 1'b1, "q_div0");
    do_op(32'hDEADBEEF, 32'd0, 1'b0, "r_div0");

    // Boundaries
    do_op(32'hFFFFFFFF, 32'd1, 1'b1, "q_max_1");
    do_op(32'hFFFFFFFF, 32'd1, 1'b0, "r_max_1");
    do_op(32'd5, 32'd9, 1'b1, "q_5_9");
    do_op(32'd5, 32'd9, 1'b0, "r_5_9");
    do_op(32'h80000000, 32'h80000000, 1'b1, "q_eq");
    do_op(32'h80000000, 32'h80000000, 1'b0, "r_eq");

    // req held across two operations; operands disturbed mid-BUSY
    bus.a_i = 32'd100; bus.b_i = 32'd7; bus.is_q_i = 1'b1; bus.req_i = 1'b1;
    cyc = 0; t1 = 0; t2 = 0;
    while (t2 == 0 && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 10) begin
        bus.a_i = 32'd55; bus.b_i = 32'd3; bus.is_q_i = 1'b0;
      end
      if (bus.ready_o) begin
        if (t1 == 0) begin
          t1 = cyc;
          chk("held_first_res", 64'(bus.result_o), 64'd14);
          bus.a_i = 32'd1000; bus.b_i = 32'd33; bus.is_q_i = 1'b0;
        end else begin
          t2 = cyc;
          chk("held_second_res", 64'(bus.result_o), 64'd10);
        end
      end
    end
    bus.req_i = 1'b0;
    chk("held_first_lat", 64'(t1), 64'd33);
    chk("held_spacing", 64'(t2 - t1), 64'd34);
    tick();

    // Abort at cycle 10
    bus.a_i = 32'd100; bus.b_i = 32'd7; bus.is_q_i = 1'b1; bus.req_i = 1'b1;
    repeat (10) tick();
    bus.req_i = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      seen |= bus.ready_o;
    end
    chk("abort_no_pulse", 64'(seen), 64'd0);
    chk("abort_hold", 64'(bus.result_o), 64'd10);
    do_op(32'd100, 32'd7, 1'b1, "after_abort");

    // Reset mid-operation at cycle 20
    bus.a_i = 32'd1000; bus.b_i = 32'd33; bus.is_q_i = 1'b0; bus.req_i = 1'b1;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_result", 64'(bus.result_o), 64'd0);
    bus.req_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      seen |= bus.ready_o;
    end
    chk("postrst_no_pulse", 64'(seen), 64'd0);
    do_op(32'd1000, 32'd33, 1'b1, "after_rst");

    // Randomized operands, mixed divisor magnitudes
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 255);
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = ($urandom_range(0, 9) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      endcase
      rq = 1'($urandom_range(0, 1));
      do_op(ra, rb, rq, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
